// File: rtl/controller.sv
// rtl/controller.sv - Multicycle ARM-subset control unit: main FSM, ALU decode, conditional flags logic.
// Optional CMP support is enabled by defining CONTROLLER_CMP_EN.
module controller (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    output logic         PCWrite,
    output logic         MemWrite,
    output logic         RegWrite,
    output logic         IRWrite,
    output logic         AdrSrc,
    output logic [1:0]   RegSrc,
    output logic [1:0]   ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ResultSrc,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   ALUControl
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_ex_r_q, cond_ex_r_d;

    logic [3:0] cond;
    logic [1:0] op;
    logic       funct_i;
    logic [3:0] cmd;
    logic       s_bit;
    logic       unused_rd;

    assign cond      = Instr[31:28];
    assign op        = Instr[27:26];
    assign funct_i   = Instr[25];
    assign cmd       = Instr[24:21];
    assign s_bit     = Instr[20];
    assign unused_rd = ^Instr[19:12];

    logic       next_pc, branch, ir_w, reg_w, mem_w, alu_op;
    logic       adr_src;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [1:0] alu_ctl;
    logic [1:0] flag_w;
    logic       cmd_writes;
    logic       cond_ex;

    always_comb begin
        state_d    = state_q;
        next_pc    = 1'b0;
        branch     = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        alu_op     = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        case (state_q)
            S_FETCH: begin
                state_d    = S_DECODE;
                next_pc    = 1'b1;
                ir_w       = 1'b1;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_DECODE: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (op)
                    2'b00:   state_d = funct_i ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_d   = s_bit ? S_MEMRD : S_MEMWR;
                alu_src_b = 2'b01;
            end
            S_MEMRD: begin
                state_d = S_MEMWB;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                state_d    = S_FETCH;
                result_src = 2'b01;
                reg_w      = 1'b1;
            end
            S_MEMWR: begin
                state_d = S_FETCH;
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            S_EXECR: begin
                state_d = S_ALUWB;
                alu_op  = 1'b1;
            end
            S_EXECI: begin
                state_d   = S_ALUWB;
                alu_src_b = 2'b01;
                alu_op    = 1'b1;
            end
            S_ALUWB: begin
                state_d = S_FETCH;
                reg_w   = cmd_writes;
            end
            S_BRANCH: begin
                state_d    = S_FETCH;
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // cmd_writes is decoded independently of ALUOp so ALUWB can suppress NOP/CMP writeback
    always_comb begin
        alu_ctl    = 2'b00;
        flag_w     = 2'b00;
        cmd_writes = 1'b0;
        case (cmd)
            4'b0100: begin alu_ctl = 2'b00; flag_w = {s_bit, s_bit}; cmd_writes = 1'b1; end
            4'b0010: begin alu_ctl = 2'b01; flag_w = {s_bit, s_bit}; cmd_writes = 1'b1; end
            4'b0000: begin alu_ctl = 2'b10; flag_w = {s_bit, 1'b0};  cmd_writes = 1'b1; end
            4'b1100: begin alu_ctl = 2'b11; flag_w = {s_bit, 1'b0};  cmd_writes = 1'b1; end
`ifdef CONTROLLER_CMP_EN
            4'b1010: begin alu_ctl = 2'b01; flag_w = 2'b11;          cmd_writes = 1'b0; end
`else
            4'b1010: begin alu_ctl = 2'b00; flag_w = 2'b00;          cmd_writes = 1'b0; end
`endif
            default: begin alu_ctl = 2'b00; flag_w = 2'b00;          cmd_writes = 1'b0; end
        endcase
        if (!alu_op) begin
            alu_ctl = 2'b00;
            flag_w  = 2'b00;
        end
    end

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = ~flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = ~flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = ~flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = ~flags_q[0];
            4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
            4'b1001: cond_ex = ~(flags_q[1] & ~flags_q[2]);
            4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex = ~(~flags_q[2] & (flags_q[3] == flags_q[0]));
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        flags_d     = flags_q;
        cond_ex_r_d = cond_ex;
        if (flag_w[1] && cond_ex) flags_d[3:2] = ALUFlags[3:2];
        if (flag_w[0] && cond_ex) flags_d[1:0] = ALUFlags[1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            flags_q     <= 4'b0000;
            cond_ex_r_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flags_q     <= flags_d;
            cond_ex_r_q <= cond_ex_r_d;
        end
    end

    assign PCWrite    = ~reset & (next_pc | (branch & cond_ex_r_q));
    assign RegWrite   = ~reset & reg_w & cond_ex_r_q;
    assign MemWrite   = ~reset & mem_w & cond_ex_r_q;
    assign IRWrite    = ~reset & ir_w;
    assign AdrSrc     = adr_src;
    assign ALUSrcA    = alu_src_a;
    assign ALUSrcB    = alu_src_b;
    assign ResultSrc  = result_src;
    assign ALUControl = alu_ctl;
    assign ImmSrc     = op;
    assign RegSrc     = {(op == 2'b01) & ~s_bit, (op == 2'b10)};

endmodule

// File: tb/tb_controller.sv
// tb/tb_controller.sv - Self-checking bench for controller against a per-instruction behavioural model.
module tb_controller;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]   RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

    controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl)
    );

    always #5 clk = ~clk;

`ifdef CONTROLLER_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,RegSrc,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,ALUControl}
    logic [16:0] obs;
    assign obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
                  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [3:0]  model_flags;
    logic [16:0] exp_q[$];

    function automatic logic [16:0] pack(input logic pcw, memw, regw, irw, adr,
                                         input logic [1:0] rs, a, b, res, imm, ctl);
        return {pcw, memw, regw, irw, adr, rs, a, b, res, imm, ctl};
    endfunction

    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: return ~c[0];
        endcase
        return base ^ c[0];
    endfunction

    // Expected per-cycle outputs for one instruction, FETCH first; also retires its flag effects.
    task automatic build_expected(input logic [31:12] ins, input logic [3:0] af);
        logic [1:0] op, rs, imm, ctl;
        logic       i, s, cp, is_add, is_sub, is_and, is_orr, is_cmp, writes, fw1, fw0;
        logic [3:0] cmd;
        op  = ins[27:26];
        i   = ins[25];
        cmd = ins[24:21];
        s   = ins[20];
        cp  = cond_holds(ins[31:28], model_flags);
        rs  = {(op == 2'b01) && !s, op == 2'b10};
        imm = op;
        exp_q.delete();
        exp_q.push_back(pack(1, 0, 0, 1, 0, rs, 2'b01, 2'b10, 2'b10, imm, 2'b00));
        exp_q.push_back(pack(0, 0, 0, 0, 0, rs, 2'b01, 2'b10, 2'b10, imm, 2'b00));
        case (op)
            2'b00: begin
                is_add = (cmd == 4'd4);
                is_sub = (cmd == 4'd2);
                is_and = (cmd == 4'd0);
                is_orr = (cmd == 4'd12);
                is_cmp = CMP_EN && (cmd == 4'd10);
                ctl    = is_add ? 2'b00 : is_sub ? 2'b01 : is_and ? 2'b10 :
                         is_orr ? 2'b11 : is_cmp ? 2'b01 : 2'b00;
                writes = is_add | is_sub | is_and | is_orr;
                fw1    = (writes & s) | is_cmp;
                fw0    = ((is_add | is_sub) & s) | is_cmp;
                exp_q.push_back(pack(0, 0, 0, 0, 0, rs, 2'b00, i ? 2'b01 : 2'b00, 2'b00, imm, ctl));
                exp_q.push_back(pack(0, 0, cp & writes, 0, 0, rs, 2'b00, 2'b00, 2'b00, imm, 2'b00));
                if (cp && fw1) model_flags[3:2] = af[3:2];
                if (cp && fw0) model_flags[1:0] = af[1:0];
            end
            2'b01: begin
                exp_q.push_back(pack(0, 0, 0, 0, 0, rs, 2'b00, 2'b01, 2'b00, imm, 2'b00));
                if (s) begin
                    exp_q.push_back(pack(0, 0, 0, 0, 1, rs, 2'b00, 2'b00, 2'b00, imm, 2'b00));
                    exp_q.push_back(pack(0, 0, cp, 0, 0, rs, 2'b00, 2'b00, 2'b01, imm, 2'b00));
                end else begin
                    exp_q.push_back(pack(0, cp, 0, 0, 1, rs, 2'b00, 2'b00, 2'b00, imm, 2'b00));
                end
            end
            2'b10: exp_q.push_back(pack(cp, 0, 0, 0, 0, rs, 2'b10, 2'b01, 2'b10, imm, 2'b00));
            default: ;
        endcase
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({PCWrite, MemWrite, RegWrite, IRWrite} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_we_1 got %b exp 0000", {PCWrite, MemWrite, RegWrite, IRWrite});
        end
        @(negedge clk);
        n_cmp++;
        if ({PCWrite, MemWrite, RegWrite, IRWrite} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_we_2 got %b exp 0000", {PCWrite, MemWrite, RegWrite, IRWrite});
        end
        #2 reset = 1'b0;
        model_flags = 4'b0000;
    endtask

    task automatic test_directed(input string name, input logic [31:12] ins_list[],
                                 input logic [3:0] af_list[]);
        foreach (ins_list[k]) begin
            Instr    = ins_list[k];
            ALUFlags = af_list[k];
            #1;
            build_expected(ins_list[k], af_list[k]);
            foreach (exp_q[j]) begin
                if (j > 0) @(negedge clk);
                n_cmp++;
                if (obs !== exp_q[j]) begin
                    n_fail++;
                    $display("FAIL %s instr=%h step=%0d got %h exp %h", name,
                             {ins_list[k], 12'h000}, j, obs, exp_q[j]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midway();
        Instr    = 20'hE5812;
        ALUFlags = 4'b0000;
        #1;
        build_expected(20'hE5812, 4'b0000);
        for (int j = 0; j < 3; j++) begin
            if (j > 0) @(negedge clk);
            n_cmp++;
            if (obs !== exp_q[j]) begin
                n_fail++;
                $display("FAIL midreset_pre step=%0d got %h exp %h", j, obs, exp_q[j]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({PCWrite, MemWrite, RegWrite, IRWrite} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midreset_memwr got %b exp 0000", {PCWrite, MemWrite, RegWrite, IRWrite});
        end
        @(negedge clk);
        n_cmp++;
        if ({PCWrite, MemWrite, RegWrite, IRWrite} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midreset_held got %b exp 0000", {PCWrite, MemWrite, RegWrite, IRWrite});
        end
        #2 reset = 1'b0;
        model_flags = 4'b0000;
    endtask

    task automatic test_random(input int count);
        logic [31:12] ins;
        logic [3:0]   af, cmd;
        for (int k = 0; k < count; k++) begin
            case ($urandom_range(0, 5))
                0: cmd = 4'd0;
                1: cmd = 4'd2;
                2: cmd = 4'd4;
                3: cmd = 4'd12;
                4: cmd = 4'd10;
                default: cmd = 4'($urandom);
            endcase
            ins = {4'($urandom), 2'($urandom), 1'($urandom), cmd, 1'($urandom), 8'($urandom)};
            if ($urandom_range(0, 2) == 0) ins[31:28] = 4'hE;
            af = 4'($urandom);
            Instr    = ins;
            ALUFlags = af;
            #1;
            build_expected(ins, af);
            foreach (exp_q[j]) begin
                if (j > 0) @(negedge clk);
                n_cmp++;
                if (obs !== exp_q[j]) begin
                    n_fail++;
                    $display("FAIL random instr=%h flags=%b step=%0d got %h exp %h",
                             {ins, 12'h000}, af, j, obs, exp_q[j]);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:12] ins_l[];
        logic [3:0]   af_l[];
        reset       = 1'b1;
        Instr       = 20'hE0812;
        ALUFlags    = 4'b0000;
        model_flags = 4'b0000;
        test_reset();

        ins_l = '{20'hE0812};
        af_l  = '{4'b0000};
        test_directed("add_reg", ins_l, af_l);

        ins_l = '{20'hE2523, 20'h0A000, 20'h1A000};
        af_l  = '{4'b0100, 4'b0000, 4'b0000};
        test_directed("branch", ins_l, af_l);

        ins_l = '{20'hE5912, 20'hE5812};
        af_l  = '{4'b1111, 4'b1111};
        test_directed("mem", ins_l, af_l);

        ins_l = '{20'hE1812, 20'hE0012, 20'hE0912, 20'h00012, 20'h10012, 20'hE1512, 20'hF0812};
        af_l  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b0000};
        test_directed("alu_ops", ins_l, af_l);

        ins_l = '{20'hE2523, 20'hEC000};
        af_l  = '{4'b0100, 4'b0000};
        test_directed("pre_reset", ins_l, af_l);
        test_reset_midway();

        ins_l = '{20'h0A000, 20'h1A000};
        af_l  = '{4'b0000, 4'b0000};
        test_directed("flags_cleared", ins_l, af_l);

        test_random(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
